crc_mem_dut: RTL and testbench

CRC-protected dual storage block with two independent channels: MEM1 holds a 32-bit word, MEM2 an 8-bit word. Each write stores data plus a CRC check value. Every cycle the stored contents are re-checked, errors are flagged, and single-bit upsets are scrubbed in place. The block sits as the leaf under the safety-analysis testbench, alongside the `intf` interface bundle, which carries the one-cycle-delayed `mem1_err_detected` observed by the bench.

---
 rtl/crc_mem_dut.sv | 163 ++++++++++++++++
 tb/tb_crc_mem_dut.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/crc_mem_dut.sv
// rtl/crc_mem_dut.sv - CRC-protected 32-bit and 8-bit storage with per-cycle check and scrub (scrub only when CRC_CORRECT_EN is defined)

// Companion bundle; the bench drives mem1_err_detected_dly with the one-cycle-delayed MEM1 flag.
interface intf;
   logic mem1_err_detected_dly;
endinterface

module crc_mem_dut (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem1_wr,
   input  logic [31:0] mem1_data_in,
   output logic [31:0] mem1_data_out,
   output logic        mem1_err_detected,
   output logic        mem1_err_corrected,
   input  logic        mem2_wr,
   input  logic [7:0]  mem2_data_in,
   output logic [7:0]  mem2_data_out,
   output logic        mem2_err_detected,
   output logic        mem2_err_corrected
);

   // CRC-8, poly 0x07, MSB-first, init 0: remainder of data*x^8 mod P.
   function automatic logic [7:0] crc8_calc(input logic [31:0] data);
      logic [7:0] crc;
      logic       fb;
      crc = '0;
      for (int i = 31; i >= 0; i--) begin
         fb  = crc[7] ^ data[i];
         crc = {crc[6:0], 1'b0};
         if (fb) crc = crc ^ 8'h07;
      end
      return crc;
   endfunction

   // CRC-4, poly 0x3, MSB-first, init 0: remainder of data*x^4 mod P.
   function automatic logic [3:0] crc4_calc(input logic [7:0] data);
      logic [3:0] crc;
      logic       fb;
      crc = '0;
      for (int i = 7; i >= 0; i--) begin
         fb  = crc[3] ^ data[i];
         crc = {crc[2:0], 1'b0};
         if (fb) crc = crc ^ 4'h3;
      end
      return crc;
   endfunction

   // Stored codewords; names are referenced by fault-injection benches.
   logic [31:0] mem1_data_q;
   logic [7:0]  mem1_crc_q;
   logic [7:0]  mem2_data_q;
   logic [3:0]  mem2_crc_q;
   logic        mem1_det_q;
   logic        mem2_det_q;

   // Syndromes of the stored words; zero means the codeword is consistent.
   logic [7:0]  mem1_syn;
   logic [3:0]  mem2_syn;

   assign mem1_syn = crc8_calc(mem1_data_q) ^ mem1_crc_q;
   assign mem2_syn = crc4_calc(mem2_data_q) ^ mem2_crc_q;

`ifdef CRC_CORRECT_EN
   // Single-bit syndrome decode. Codeword bit order is {data, crc}, so data
   // bit i sits at position i+k. Every comparison is against a constant, so
   // each mask is a fixed lookup on the syndrome; at most one bit can match.
   function automatic logic [39:0] crc8_flip_mask(input logic [7:0] syn);
      logic [39:0] m;
      m = '0;
      for (int i = 0; i < 32; i++)
         if (crc8_calc(32'd1 << i) == syn) m[i + 8] = 1'b1;
      for (int j = 0; j < 8; j++)
         if ((8'd1 << j) == syn) m[j] = 1'b1;
      return m;
   endfunction

   function automatic logic [11:0] crc4_flip_mask(input logic [3:0] syn);
      logic [11:0] m;
      m = '0;
      for (int i = 0; i < 8; i++)
         if (crc4_calc(8'd1 << i) == syn) m[i + 4] = 1'b1;
      for (int j = 0; j < 4; j++)
         if ((4'd1 << j) == syn) m[j] = 1'b1;
      return m;
   endfunction

   logic [39:0] mem1_flip;
   logic [11:0] mem2_flip;
   logic        mem1_fixable;
   logic        mem2_fixable;
   logic        mem1_cor_q;
   logic        mem2_cor_q;

   assign mem1_flip    = crc8_flip_mask(mem1_syn);
   assign mem2_flip    = crc4_flip_mask(mem2_syn);
   assign mem1_fixable = |mem1_flip;
   assign mem2_fixable = |mem2_flip;
`endif

   // MEM1 storage: write has priority over scrub; detect flag follows the stored syndrome.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         mem1_data_q <= '0;
         mem1_crc_q  <= '0;
         mem1_det_q  <= 1'b0;
      end else if (mem1_wr) begin
         mem1_data_q <= mem1_data_in;
         mem1_crc_q  <= crc8_calc(mem1_data_in);
         mem1_det_q  <= 1'b0;
      end else begin
         mem1_det_q <= |mem1_syn;
`ifdef CRC_CORRECT_EN
         if (mem1_fixable)
            {mem1_data_q, mem1_crc_q} <= {mem1_data_q, mem1_crc_q} ^ mem1_flip;
`endif
      end
   end

   // MEM2 storage: same structure as MEM1, fully independent.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         mem2_data_q <= '0;
         mem2_crc_q  <= '0;
         mem2_det_q  <= 1'b0;
      end else if (mem2_wr) begin
         mem2_data_q <= mem2_data_in;
         mem2_crc_q  <= crc4_calc(mem2_data_in);
         mem2_det_q  <= 1'b0;
      end else begin
         mem2_det_q <= |mem2_syn;
`ifdef CRC_CORRECT_EN
         if (mem2_fixable)
            {mem2_data_q, mem2_crc_q} <= {mem2_data_q, mem2_crc_q} ^ mem2_flip;
`endif
      end
   end

`ifdef CRC_CORRECT_EN
   // Correction pulses: high for the edge at which a scrub write-back happened.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         mem1_cor_q <= 1'b0;
         mem2_cor_q <= 1'b0;
      end else begin
         mem1_cor_q <= !mem1_wr && mem1_fixable;
         mem2_cor_q <= !mem2_wr && mem2_fixable;
      end
   end

   assign mem1_err_corrected = mem1_cor_q;
   assign mem2_err_corrected = mem2_cor_q;
`else
   assign mem1_err_corrected = 1'b0;
   assign mem2_err_corrected = 1'b0;
`endif

   assign mem1_data_out     = mem1_data_q;
   assign mem2_data_out     = mem2_data_q;
   assign mem1_err_detected = mem1_det_q;
   assign mem2_err_detected = mem2_det_q;

endmodule

// File: tb/tb_crc_mem_dut.sv
// tb/tb_crc_mem_dut.sv - directed self-checking bench for crc_mem_dut (both CRC_CORRECT_EN builds)

module tb_crc_mem_dut;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem1_wr;
   logic [31:0] mem1_data_in;
   logic [31:0] mem1_data_out;
   logic        mem1_err_detected;
   logic        mem1_err_corrected;
   logic        mem2_wr;
   logic [7:0]  mem2_data_in;
   logic [7:0]  mem2_data_out;
   logic        mem2_err_detected;
   logic        mem2_err_corrected;

   int tests = 0;
   int fails = 0;

`ifdef CRC_CORRECT_EN
   localparam bit CORR = 1'b1;
`else
   localparam bit CORR = 1'b0;
`endif

   crc_mem_dut dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .mem1_wr            (mem1_wr),
      .mem1_data_in       (mem1_data_in),
      .mem1_data_out      (mem1_data_out),
      .mem1_err_detected  (mem1_err_detected),
      .mem1_err_corrected (mem1_err_corrected),
      .mem2_wr            (mem2_wr),
      .mem2_data_in       (mem2_data_in),
      .mem2_data_out      (mem2_data_out),
      .mem2_err_detected  (mem2_err_detected),
      .mem2_err_corrected (mem2_err_corrected)
   );

   intf u_intf();

   always #5 clk = ~clk;

   // One-cycle-delayed copy of the MEM1 detect flag.
   always @(posedge clk) u_intf.mem1_err_detected_dly <= mem1_err_detected;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_d1"},   mem1_data_out, 32'h0);
      check({tag, "_det1"}, {31'h0, mem1_err_detected}, 32'h0);
      check({tag, "_cor1"}, {31'h0, mem1_err_corrected}, 32'h0);
      check({tag, "_d2"},   {24'h0, mem2_data_out}, 32'h0);
      check({tag, "_det2"}, {31'h0, mem2_err_detected}, 32'h0);
      check({tag, "_cor2"}, {31'h0, mem2_err_corrected}, 32'h0);
   endtask

   initial begin
      rst_n        = 1'b1;
      mem1_wr      = 1'b0;
      mem1_data_in = '0;
      mem2_wr      = 1'b0;
      mem2_data_in = '0;

      // Reset held, then released with no writes.
      step();
      step();
      check_all_zero("rst_hold");
      rst_n = 1'b0;
      step();
      step();
      check_all_zero("rst_rel");
      check("rst_crc1", {24'h0, dut.mem1_crc_q}, 32'h0);
      check("rst_crc2", {28'h0, dut.mem2_crc_q}, 32'h0);

      // MEM1 write 1: CRC-8 of x^0 is x^8 mod P = 0x07.
      mem1_wr = 1'b1; mem1_data_in = 32'h0000_0001;
      step();
      mem1_wr = 1'b0;
      check("wr1_d",   mem1_data_out, 32'h0000_0001);
      check("wr1_crc", {24'h0, dut.mem1_crc_q}, 32'h07);
      check("wr1_det", {31'h0, mem1_err_detected}, 32'h0);
      check("wr1_cor", {31'h0, mem1_err_corrected}, 32'h0);

      // MEM2 write 1: CRC-4 is x^4 mod P = 0x3.
      mem2_wr = 1'b1; mem2_data_in = 8'h01;
      step();
      mem2_wr = 1'b0;
      check("wr2_d",   {24'h0, mem2_data_out}, 32'h01);
      check("wr2_crc", {28'h0, dut.mem2_crc_q}, 32'h3);
      check("wr2_det", {31'h0, mem2_err_detected}, 32'h0);
      check("wr2_cor", {31'h0, mem2_err_corrected}, 32'h0);

      // Flip MEM1 data bit 5 (syndrome 0xE0, a single-bit syndrome).
      force dut.mem1_data_q = 32'h0000_0021;
      #1;
      release dut.mem1_data_q;
      step();
      check("flip1_det", {31'h0, mem1_err_detected}, 32'h1);
      check("flip1_cor", {31'h0, mem1_err_corrected}, {31'h0, CORR});
      check("flip1_d",   mem1_data_out, CORR ? 32'h0000_0001 : 32'h0000_0021);
      check("flip1_det2", {31'h0, mem2_err_detected}, 32'h0);
      step();
      check("flip1b_det", {31'h0, mem1_err_detected}, {31'h0, !CORR});
      check("flip1b_cor", {31'h0, mem1_err_corrected}, 32'h0);
      check("flip1b_d",   mem1_data_out, CORR ? 32'h0000_0001 : 32'h0000_0021);
      check("flip1b_crc", {24'h0, dut.mem1_crc_q}, 32'h07);
      check("flip1b_dly", {31'h0, u_intf.mem1_err_detected_dly}, 32'h1);
      step();
      check("flip1c_det", {31'h0, mem1_err_detected}, {31'h0, !CORR});
      check("flip1c_dly", {31'h0, u_intf.mem1_err_detected_dly}, {31'h0, !CORR});

      // Corruption together with a write: write wins. CRC-8 of x^8 is x^16 mod P = 0x15.
      force dut.mem1_data_q = 32'h0000_00FF;
      mem1_wr = 1'b1; mem1_data_in = 32'h0000_0100;
      #1;
      release dut.mem1_data_q;
      step();
      mem1_wr = 1'b0;
      check("wrerr_d",   mem1_data_out, 32'h0000_0100);
      check("wrerr_crc", {24'h0, dut.mem1_crc_q}, 32'h15);
      check("wrerr_det", {31'h0, mem1_err_detected}, 32'h0);
      check("wrerr_cor", {31'h0, mem1_err_corrected}, 32'h0);
      step();
      check("wrerr2_det", {31'h0, mem1_err_detected}, 32'h0);
      check("wrerr2_dly", {31'h0, u_intf.mem1_err_detected_dly}, 32'h0);

      // MEM2 data bits 0 and 5 flipped: syndrome 0x3^0xA = 0x9, matches no single bit.
      force dut.mem2_data_q = 8'h20;
      #1;
      release dut.mem2_data_q;
      step();
      check("unc_det", {31'h0, mem2_err_detected}, 32'h1);
      check("unc_cor", {31'h0, mem2_err_corrected}, 32'h0);
      check("unc_d",   {24'h0, mem2_data_out}, 32'h20);
      check("unc_det1", {31'h0, mem1_err_detected}, 32'h0);
      step();
      check("unc2_det", {31'h0, mem2_err_detected}, 32'h1);
      check("unc2_d",   {24'h0, mem2_data_out}, 32'h20);

      // Write 0xA5 clears it. CRC-4 = 0xE^0xA^0xC^0x3 = 0xB.
      mem2_wr = 1'b1; mem2_data_in = 8'hA5;
      step();
      mem2_wr = 1'b0;
      check("a5_d",   {24'h0, mem2_data_out}, 32'hA5);
      check("a5_crc", {28'h0, dut.mem2_crc_q}, 32'hB);
      check("a5_det", {31'h0, mem2_err_detected}, 32'h0);
      step();
      check("a5b_det", {31'h0, mem2_err_detected}, 32'h0);

      // MEM2 CRC bit 1 flipped: syndrome 0x2, correctable.
      force dut.mem2_crc_q = 4'h9;
      #1;
      release dut.mem2_crc_q;
      step();
      check("crcf_det", {31'h0, mem2_err_detected}, 32'h1);
      check("crcf_cor", {31'h0, mem2_err_corrected}, {31'h0, CORR});
      step();
      check("crcf2_det", {31'h0, mem2_err_detected}, {31'h0, !CORR});
      check("crcf2_crc", {28'h0, dut.mem2_crc_q}, CORR ? 32'hB : 32'h9);
      check("crcf2_d",   {24'h0, mem2_data_out}, 32'hA5);

      // Reset mid-operation takes effect without a clock edge.
      #2;
      rst_n = 1'b1;
      #1;
      check("arst_d1",   mem1_data_out, 32'h0);
      check("arst_d2",   {24'h0, mem2_data_out}, 32'h0);
      check("arst_det2", {31'h0, mem2_err_detected}, 32'h0);
      check("arst_crc1", {24'h0, dut.mem1_crc_q}, 32'h0);
      #3;
      rst_n = 1'b0;
      step();
      check_all_zero("post_arst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
